zpulse_stats: RTL and testbench
===============================

Name: zpulse_stats

Overview:
- Upstream feeder of the LCD draw sequencer.
- Takes raw photon pulse-counter samples from the gate counter and keeps a circular history of the last DEPTH points.
- Produces the latest sample, a saturating accumulated sum, and the history maximum and minimum, then emits a one-cycle update strobe.
- The draw sequencer latches these outputs on its data-update and max/min inputs.

Parameters:
DEPTH, 600, history points kept (one per displayed waveform column); legal range 2..1023.
AW, 10, history address/count width; must satisfy 2^AW > DEPTH.

Ports:
clk  input  1  system clock.
rst  input  1  reset, asynchronous, active-high.
iSample_Valid  input  1  one-cycle strobe: new pulse-counter sample present.
iSample  input  32  new pulse-counter value.
iClear  input  1  synchronous clear of history and statistics.
oData_Update  output  1  one-cycle strobe: all outputs below refreshed.
oPulse_Counter  output  32  last accepted sample.
oPulseCounter_Accumulated  output  32  saturating sum of samples since reset/clear.
oMaxPulseCounter  output  16  max over valid history entries.
oMinPulseCounter  output  16  min over valid history entries.
oPoint_Count  output  AW  valid history entries, 0..DEPTH.
oBusy  output  1  high in any state except IDLE.
oOverrun  output  1  one-cycle strobe: a pending sample was overwritten.

Behaviour:
- Reset (rst high, async): all outputs 0. Write pointer, count, pending flag and accumulator are 0. FSM is IDLE. History RAM contents are don't-care.
- History stores min(iSample, 16'hFFFF): 16-bit saturate, not truncate. oPulse_Counter and the accumulator use the full 32 bits.
- Accumulator: sum += sample, clamped at 32'hFFFFFFFF, never wraps. Updated in WRITE.
- History RAM: single write port, single read port, 1-cycle registered read latency (block-RAM inferable).
- Pending register: 1 deep. A sample arriving while oBusy=1 is stored in it.
  - If the pending register is already full, the new sample replaces it and oOverrun pulses for one cycle.
  - Samples are never lost while IDLE.
- FSM states:
  - IDLE: on iSample_Valid, or on the pending flag (the live sample has priority), capture the sample and go to WRITE. A live sample arriving together with a pending one replaces pending with the live value; oOverrun pulses.
  - WRITE (1 cycle):
    - Write RAM[wr_ptr], update oPulse_Counter and the accumulator.
    - wr_ptr wraps DEPTH-1 -> 0.
    - count increments, saturating at DEPTH.
    - Reset the scan max to 0 and the scan min to 16'hFFFF.
    - Go to SCAN.
  - SCAN (N cycles, N = count after write): issue reads at addresses 0..N-1, one per cycle. Compare returned data one cycle later. Go to LAST after address N-1 is issued.
  - LAST (1 cycle): compare the final read datum, go to PUBLISH.
  - PUBLISH (1 cycle): register the scan max/min to the outputs, update oPoint_Count, assert oData_Update, go to IDLE.
- Latency: sample accepted at clock edge T -> oData_Update high in the cycle after edge T+N+3. Throughput is 1 sample per N+4 cycles.
- All outputs hold their values between strobes. oMax/oMin/oPoint_Count change only in PUBLISH or on clear.
- iClear (synchronous, any state, highest priority):
  - Next cycle: FSM is IDLE, and wr_ptr, count, accumulator, pending flag, oPulse_Counter, oMax, oMin and oPoint_Count are 0.
  - The scan in progress is aborted; no oData_Update is issued.
  - An iSample_Valid in the same cycle is dropped.
- Empty history (after reset/clear, before the first publish): max = min = 0.
- Full history: the oldest entry is overwritten, and the scan always covers all DEPTH entries.
- Reset asserted mid-scan: immediate return to reset values; no strobe.

Test Plan:
- DEPTH=4. Samples 10, 3, 7 spaced 20 cycles apart. Publishes are N=1,2,3, at 4, 5 and 6 cycles after each accept. Final outputs: max=10, min=3, acc=20, count=3, oPulse_Counter=7.
- DEPTH=4, wrap. Samples 10,3,7,8,9,11 with ample spacing. After the 5th sample the history is 9,3,7,8 -> max 9, min 3. After the 6th it is 9,11,7,8 -> max 11, min 7. count stays 4.
- Saturation. Sample 32'h0001_2345 -> history 16'hFFFF, so max=min=FFFF and oPulse_Counter=0x12345. Accumulator preset near full by samples 32'hFFFF_FFF0 and 32'h20 -> acc=32'hFFFFFFFF.
- Back-to-back. Samples A=5, B=6, C=7 on consecutive cycles. A is processed; C overwrites pending B with one oOverrun pulse; C is processed next. Result: two oData_Update strobes, acc=12.
- Clear during SCAN. DEPTH=600 with 100 samples loaded, then a new sample, then iClear 20 cycles later. Next cycle: all statistics are 0, oBusy=0, no strobe follows. A subsequent sample 42 gives max=min=42, count=1.
- Async reset mid-WRITE. rst pulses between edges; outputs go to 0 immediately. First sample after release gives count=1, acc equal to that sample.

Source files
------------

// File: rtl/zpulse_stats.sv
// Pulse-counter statistics: circular history of the last DEPTH samples, saturating
// accumulator, and history max/min refreshed by a sequential scan after every sample.
module zpulse_stats #(
    parameter int unsigned DEPTH = 600,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iSample_Valid,
    input  logic [31:0]   iSample,
    input  logic          iClear,
    output logic          oData_Update,
    output logic [31:0]   oPulse_Counter,
    output logic [31:0]   oPulseCounter_Accumulated,
    output logic [15:0]   oMaxPulseCounter,
    output logic [15:0]   oMinPulseCounter,
    output logic [AW-1:0] oPoint_Count,
    output logic          oBusy,
    output logic          oOverrun
);

    localparam int unsigned DW = 32;
    localparam int unsigned HW = 16;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SCAN,
        ST_LAST,
        ST_PUBLISH
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   sample_q, sample_d;
    logic            pend_vld_q, pend_vld_d;
    logic [DW-1:0]   pend_q, pend_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   count_q, count_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   scan_addr_q, scan_addr_d;
    logic            rd_vld_q, rd_vld_d;
    logic [HW-1:0]   scan_max_q, scan_max_d;
    logic [HW-1:0]   scan_min_q, scan_min_d;

    logic            upd_q, upd_d;
    logic [DW-1:0]   pulse_q, pulse_d;
    logic [HW-1:0]   max_q, max_d;
    logic [HW-1:0]   min_q, min_d;
    logic [AW-1:0]   pcount_q, pcount_d;
    logic            busy_q, busy_d;
    logic            ovr_q, ovr_d;

    logic            ram_we_c;
    logic [HW-1:0]   hist_c;
    logic [DW:0]     acc_sum_c;
    logic [HW-1:0]   ram_rd_q;
    logic [HW-1:0]   mem [DEPTH];

    // History RAM: one write port, one registered read port
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            mem[wr_ptr_q[IW-1:0]] <= hist_c;
        end
        ram_rd_q <= mem[scan_addr_q[IW-1:0]];
    end

    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        pend_vld_d  = pend_vld_q;
        pend_d      = pend_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        acc_d       = acc_q;
        scan_addr_d = scan_addr_q;
        rd_vld_d    = 1'b0;
        scan_max_d  = scan_max_q;
        scan_min_d  = scan_min_q;
        upd_d       = 1'b0;
        pulse_d     = pulse_q;
        max_d       = max_q;
        min_d       = min_q;
        pcount_d    = pcount_q;
        ovr_d       = 1'b0;
        ram_we_c    = 1'b0;
        hist_c      = (sample_q[DW-1:HW] != '0) ? {HW{1'b1}} : sample_q[HW-1:0];
        acc_sum_c   = {1'b0, acc_q} + {1'b0, sample_q};

        // Samples arriving while busy park in the one-deep pending slot
        if (state_q != ST_IDLE && iSample_Valid) begin
            pend_vld_d = 1'b1;
            pend_d     = iSample;
            ovr_d      = pend_vld_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (iSample_Valid) begin
                    sample_d = iSample;
                    state_d  = ST_WRITE;
                    if (pend_vld_q) begin
                        pend_vld_d = 1'b0;
                        ovr_d      = 1'b1;
                    end
                end else if (pend_vld_q) begin
                    sample_d   = pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ram_we_c    = 1'b1;
                pulse_d     = sample_q;
                acc_d       = acc_sum_c[DW] ? {DW{1'b1}} : acc_sum_c[DW-1:0];
                wr_ptr_d    = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
                count_d     = (count_q == AW'(DEPTH)) ? count_q : count_q + AW'(1);
                scan_max_d  = '0;
                scan_min_d  = {HW{1'b1}};
                scan_addr_d = '0;
                state_d     = ST_SCAN;
            end
            ST_SCAN: begin
                rd_vld_d = 1'b1;
                if (scan_addr_q == count_q - AW'(1)) begin
                    state_d = ST_LAST;
                end else begin
                    scan_addr_d = scan_addr_q + AW'(1);
                end
            end
            ST_LAST: begin
                state_d = ST_PUBLISH;
            end
            ST_PUBLISH: begin
                max_d    = scan_max_q;
                min_d    = scan_min_q;
                pcount_d = count_q;
                upd_d    = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read data lags its address by one cycle
        if (rd_vld_q) begin
            if (ram_rd_q > scan_max_q) scan_max_d = ram_rd_q;
            if (ram_rd_q < scan_min_q) scan_min_d = ram_rd_q;
        end

        if (iClear) begin
            state_d     = ST_IDLE;
            pend_vld_d  = 1'b0;
            wr_ptr_d    = '0;
            count_d     = '0;
            acc_d       = '0;
            scan_addr_d = '0;
            rd_vld_d    = 1'b0;
            upd_d       = 1'b0;
            pulse_d     = '0;
            max_d       = '0;
            min_d       = '0;
            pcount_d    = '0;
            ovr_d       = 1'b0;
            ram_we_c    = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sample_q    <= '0;
            pend_vld_q  <= 1'b0;
            pend_q      <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            scan_addr_q <= '0;
            rd_vld_q    <= 1'b0;
            scan_max_q  <= '0;
            scan_min_q  <= '0;
            upd_q       <= 1'b0;
            pulse_q     <= '0;
            max_q       <= '0;
            min_q       <= '0;
            pcount_q    <= '0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            pend_vld_q  <= pend_vld_d;
            pend_q      <= pend_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            scan_addr_q <= scan_addr_d;
            rd_vld_q    <= rd_vld_d;
            scan_max_q  <= scan_max_d;
            scan_min_q  <= scan_min_d;
            upd_q       <= upd_d;
            pulse_q     <= pulse_d;
            max_q       <= max_d;
            min_q       <= min_d;
            pcount_q    <= pcount_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
        end
    end

    assign oData_Update              = upd_q;
    assign oPulse_Counter            = pulse_q;
    assign oPulseCounter_Accumulated = acc_q;
    assign oMaxPulseCounter          = max_q;
    assign oMinPulseCounter          = min_q;
    assign oPoint_Count              = pcount_q;
    assign oBusy                     = busy_q;
    assign oOverrun                  = ovr_q;

endmodule

// File: tb/tb_zpulse_stats.sv
// Directed bench for zpulse_stats: a DEPTH=4 instance for history behaviour and a
// DEPTH=600 instance for clear during a long scan.
module tb_zpulse_stats;

    logic        clk;
    logic        rst;

    logic        v4, c4;
    logic [31:0] s4;
    logic        upd4, busy4, ovr4;
    logic [31:0] pc4, acc4;
    logic [15:0] max4, min4;
    logic [9:0]  cnt4;

    logic        v6, c6;
    logic [31:0] s6;
    logic        upd6, busy6, ovr6;
    logic [31:0] pc6, acc6;
    logic [15:0] max6, min6;
    logic [9:0]  cnt6;

    int checks = 0;
    int errors = 0;

    zpulse_stats #(.DEPTH(4), .AW(10)) dut4 (
        .clk(clk), .rst(rst),
        .iSample_Valid(v4), .iSample(s4), .iClear(c4),
        .oData_Update(upd4), .oPulse_Counter(pc4), .oPulseCounter_Accumulated(acc4),
        .oMaxPulseCounter(max4), .oMinPulseCounter(min4), .oPoint_Count(cnt4),
        .oBusy(busy4), .oOverrun(ovr4)
    );

    zpulse_stats #(.DEPTH(600), .AW(10)) dut6 (
        .clk(clk), .rst(rst),
        .iSample_Valid(v6), .iSample(s6), .iClear(c6),
        .oData_Update(upd6), .oPulse_Counter(pc6), .oPulseCounter_Accumulated(acc6),
        .oMaxPulseCounter(max6), .oMinPulseCounter(min6), .oPoint_Count(cnt6),
        .oBusy(busy6), .oOverrun(ovr6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one sample into the DEPTH=4 instance; lat = negedges until the strobe
    task automatic send4(input logic [31:0] v, output int lat);
        @(negedge clk);
        v4 = 1'b1;
        s4 = v;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            v4 = 1'b0;
            if (upd4) begin
                lat = k;
                break;
            end
        end
        check("strobe4_seen", 32'(lat != 0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic send6(input logic [31:0] v);
        int lat;
        @(negedge clk);
        v6 = 1'b1;
        s6 = v;
        lat = 0;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            v6 = 1'b0;
            if (upd6) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check("strobe6_seen", 32'd0, 32'd1);
    endtask

    task automatic clear4();
        @(negedge clk);
        c4 = 1'b1;
        @(negedge clk);
        c4 = 1'b0;
    endtask

    initial begin
        int lat;
        int n_upd;
        int n_ovr;
        rst = 1'b1;
        v4 = 1'b0; c4 = 1'b0; s4 = '0;
        v6 = 1'b0; c6 = 1'b0; s6 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_upd", 32'(upd4), 32'd0);
        check("rst_pc", pc4, 32'd0);
        check("rst_acc", acc4, 32'd0);
        check("rst_max", 32'(max4), 32'd0);
        check("rst_min", 32'(min4), 32'd0);
        check("rst_cnt", 32'(cnt4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_ovr", 32'(ovr4), 32'd0);

        // Basic accumulation, latency N+4 negedges after drive
        send4(32'd10, lat);
        check("s1_lat", 32'(lat), 32'd5);
        check("s1_max", 32'(max4), 32'd10);
        check("s1_min", 32'(min4), 32'd10);
        check("s1_cnt", 32'(cnt4), 32'd1);
        repeat (15) @(negedge clk);
        send4(32'd3, lat);
        check("s2_lat", 32'(lat), 32'd6);
        check("s2_max", 32'(max4), 32'd10);
        check("s2_min", 32'(min4), 32'd3);
        repeat (15) @(negedge clk);
        send4(32'd7, lat);
        check("s3_lat", 32'(lat), 32'd7);
        check("s3_max", 32'(max4), 32'd10);
        check("s3_min", 32'(min4), 32'd3);
        check("s3_acc", acc4, 32'd20);
        check("s3_cnt", 32'(cnt4), 32'd3);
        check("s3_pc", pc4, 32'd7);
        check("s3_busy", 32'(busy4), 32'd0);

        // Wrap of the circular history
        send4(32'd8, lat);
        check("w4_lat", 32'(lat), 32'd8);
        check("w4_cnt", 32'(cnt4), 32'd4);
        send4(32'd9, lat);
        check("w5_max", 32'(max4), 32'd9);
        check("w5_min", 32'(min4), 32'd3);
        check("w5_cnt", 32'(cnt4), 32'd4);
        send4(32'd11, lat);
        check("w6_lat", 32'(lat), 32'd8);
        check("w6_max", 32'(max4), 32'd11);
        check("w6_min", 32'(min4), 32'd7);
        check("w6_cnt", 32'(cnt4), 32'd4);
        check("w6_acc", acc4, 32'd48);

        // Saturation of history entry and accumulator
        clear4();
        check("clr_acc", acc4, 32'd0);
        check("clr_cnt", 32'(cnt4), 32'd0);
        check("clr_max", 32'(max4), 32'd0);
        check("clr_pc", pc4, 32'd0);
        send4(32'h0001_2345, lat);
        check("sat_max", 32'(max4), 32'h0000_FFFF);
        check("sat_min", 32'(min4), 32'h0000_FFFF);
        check("sat_pc", pc4, 32'h0001_2345);
        clear4();
        send4(32'hFFFF_FFF0, lat);
        check("acc_pre", acc4, 32'hFFFF_FFF0);
        send4(32'h0000_0020, lat);
        check("acc_sat", acc4, 32'hFFFF_FFFF);
        send4(32'd5, lat);
        check("acc_hold", acc4, 32'hFFFF_FFFF);
        check("acc_min", 32'(min4), 32'd5);
        check("acc_max", 32'(max4), 32'h0000_FFFF);

        // Back-to-back samples overrun the pending slot
        clear4();
        @(negedge clk);
        v4 = 1'b1; s4 = 32'd5;
        @(negedge clk);
        s4 = 32'd6;
        @(negedge clk);
        s4 = 32'd7;
        n_upd = 0;
        n_ovr = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            v4 = 1'b0;
            if (upd4) n_upd++;
            if (ovr4) n_ovr++;
        end
        check("b2b_upd", 32'(n_upd), 32'd2);
        check("b2b_ovr", 32'(n_ovr), 32'd1);
        check("b2b_acc", acc4, 32'd12);
        check("b2b_pc", pc4, 32'd7);
        check("b2b_cnt", 32'(cnt4), 32'd2);
        check("b2b_max", 32'(max4), 32'd7);
        check("b2b_min", 32'(min4), 32'd5);

        // Clear during a long scan on the DEPTH=600 instance
        for (int i = 0; i < 100; i++) send6(32'(100 + i));
        check("d600_cnt", 32'(cnt6), 32'd100);
        check("d600_max", 32'(max6), 32'd199);
        check("d600_min", 32'(min6), 32'd100);
        check("d600_acc", acc6, 32'd14950);
        @(negedge clk);
        v6 = 1'b1; s6 = 32'd5;
        repeat (20) begin
            @(negedge clk);
            v6 = 1'b0;
        end
        check("scan_busy", 32'(busy6), 32'd1);
        c6 = 1'b1;
        @(negedge clk);
        c6 = 1'b0;
        check("sclr_busy", 32'(busy6), 32'd0);
        check("sclr_acc", acc6, 32'd0);
        check("sclr_max", 32'(max6), 32'd0);
        check("sclr_min", 32'(min6), 32'd0);
        check("sclr_cnt", 32'(cnt6), 32'd0);
        check("sclr_pc", pc6, 32'd0);
        check("sclr_upd", 32'(upd6), 32'd0);
        n_upd = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (upd6) n_upd++;
        end
        check("sclr_nostrobe", 32'(n_upd), 32'd0);
        send6(32'd42);
        check("post_max", 32'(max6), 32'd42);
        check("post_min", 32'(min6), 32'd42);
        check("post_cnt", 32'(cnt6), 32'd1);
        check("post_acc", acc6, 32'd42);

        // Async reset while the DEPTH=4 instance sits in WRITE
        @(negedge clk);
        v4 = 1'b1; s4 = 32'd99;
        @(posedge clk);
        #1;
        v4 = 1'b0;
        check("mw_busy", 32'(busy4), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy4), 32'd0);
        check("arst_acc", acc4, 32'd0);
        check("arst_pc", pc4, 32'd0);
        check("arst_cnt", 32'(cnt4), 32'd0);
        check("arst_max", 32'(max4), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_upd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (upd4) n_upd++;
        end
        check("arst_nostrobe", 32'(n_upd), 32'd0);
        send4(32'd17, lat);
        check("arst_lat", 32'(lat), 32'd5);
        check("arst_cnt1", 32'(cnt4), 32'd1);
        check("arst_acc1", acc4, 32'd17);
        check("arst_max1", 32'(max4), 32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
